fir_filter_mc: RTL and testbench
================================

Name: fir_filter_mc

Overview:
- Parametrised, multi-channel successor to the single-channel 5-tap FIR filter.
- One time-multiplexed MAC serves CHANNELS independent delay lines.
- Coefficients are loadable at runtime. Multiplier pipeline depth is configurable.
- Sits between the sample source and the downstream result consumer. Uses the same valid/ready handshake style as the existing filter.

Parameters:
- WIDTH, 16, signed sample and coefficient width.
- LENGTH, 8, tap count (2..64).
- CHANNELS, 4, independent channels (1..16).
- MULT_STAGES, 4, multiplier pipeline latency in cycles (1..64).
- OUT_WIDTH, 2*WIDTH+$clog2(LENGTH), accumulator and output width.
- FRAC_BITS, 15, right shift applied in saturated mode only.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- FIR_input  in  WIDTH  signed sample.
- in_channel  in  $clog2(CHANNELS) (min 1)  channel of FIR_input.
- input_valid  in  1  sample offered.
- ready_for_input  out  1  block idle; can accept a sample.
- coef_wr_en  in  1  coefficient write strobe.
- coef_addr  in  $clog2(LENGTH)  tap index.
- coef_data  in  WIDTH  signed coefficient.
- coef_wr_ignored  out  1  one-cycle pulse: write rejected (block busy).
- FIR_output  out  OUT_WIDTH  signed result.
- out_channel  out  $clog2(CHANNELS) (min 1)  channel of FIR_output.
- output_valid  out  1  one-cycle result strobe.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - All delay lines, coefficients, accumulator and multiplier pipeline clear to 0.
  - ready_for_input=1; output_valid=0; coef_wr_ignored=0; FIR_output=0; out_channel=0.
- States: IDLE → LOAD → CALC → DRAIN → OUTPUT → IDLE.
- IDLE:
  - ready_for_input=1.
  - Handshake at a rising edge with input_valid&&ready_for_input: capture FIR_input and in_channel, go to LOAD.
  - in_channel ≥ CHANNELS: sample is dropped, state stays IDLE.
- LOAD (1 cycle):
  - Shift the captured channel's delay line; new sample enters x[0] and the oldest sample is discarded.
  - Clear the accumulator. Go to CALC.
- CALC (LENGTH cycles):
  - Tap counter k runs 0..LENGTH-1; one product x[k]*c[k] is issued per cycle.
  - counter_co is high when k=LENGTH-1; CALC then goes to DRAIN.
- DRAIN (MULT_STAGES cycles):
  - Products leaving the multiplier pipeline add into the accumulator. This continues until the last product is summed.
- OUTPUT (1 cycle): output_valid=1 with FIR_output and out_channel; then IDLE.
- Latency: output_valid is high in cycle LENGTH+MULT_STAGES+2 after the handshake edge. Next ready_for_input is high in the following cycle.
- ready_for_input is low in LOAD, CALC, DRAIN and OUTPUT. input_valid is ignored while ready_for_input is low.
- FIR_output holds its value until the next OUTPUT.
- Arithmetic:
  - Products are 2*WIDTH signed and sign-extended to OUT_WIDTH.
  - The accumulator cannot overflow at OUT_WIDTH.
- Coefficient writes:
  - Accepted only in IDLE; they take effect from the next handshake.
  - coef_wr_en outside IDLE: write discarded, coef_wr_ignored pulses in the next cycle.
  - Write in the same cycle as a handshake: write is accepted and is visible to that sample.
- Channels never share state. A channel's history changes only on its own samples.
- Reset mid-operation: computation aborted, no output_valid, all histories cleared.

Optional Feature:
- Macro: FIR_SAT_OUT_EN.
- Defined:
  - Accumulator is arithmetically shifted right by FRAC_BITS.
  - Result saturates to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1], sign-extended onto FIR_output.
  - Saturation adds one register stage; latency becomes LENGTH+MULT_STAGES+3.
- Undefined: full-precision OUT_WIDTH result, base latency.

Test Plan:
- Impulse, channel 0:
  - Stimulus: coefs 1..8 written; ch0 input sequence 1 then seven 0s.
  - Response: outputs 1,2,...,8 on out_channel=0; each output_valid exactly 14 cycles after its handshake (defaults).
- Channel isolation:
  - Stimulus: all coefs 1; ch1 gets 100; ch2 gets 5; ch1 gets 100.
  - Response: ch1 outputs 100 then 200; ch2 outputs 5.
- Extremes:
  - Stimulus: all coefs -32768; 8 samples of -32768 on ch3.
  - Response: final output +8589934592, with no overflow at OUT_WIDTH=35.
- Coefficient write while busy:
  - Stimulus: write during CALC.
  - Response: coef_wr_ignored pulses once; results are unchanged versus the prior coefs.
- Reset mid-operation:
  - Stimulus: reset_n low during DRAIN.
  - Response: no output_valid; ready_for_input=1 immediately; next ch0 impulse output equals 1*c[0].
- FIR_SAT_OUT_EN:
  - Stimulus: coefs 32767, input 32767 ×8 with FRAC_BITS=15.
  - Response: output saturates to 32767; latency 15 cycles.

Source files
------------

// File: rtl/fir_filter_mc_if.sv
// Sample, coefficient and result bus of the multi-channel FIR filter.
// The master side offers samples and coefficient writes and consumes results;
// the slave side is the filter itself.
interface fir_filter_mc_if #(
  parameter int WIDTH     = 16,
  parameter int LENGTH    = 8,
  parameter int CHANNELS  = 4,
  parameter int OUT_WIDTH = 2*WIDTH+$clog2(LENGTH)
);
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ADDR_W = $clog2(LENGTH);

  logic signed [WIDTH-1:0]     FIR_input;
  logic        [CH_W-1:0]      in_channel;
  logic                        input_valid;
  logic                        ready_for_input;
  logic                        coef_wr_en;
  logic        [ADDR_W-1:0]    coef_addr;
  logic signed [WIDTH-1:0]     coef_data;
  logic                        coef_wr_ignored;
  logic signed [OUT_WIDTH-1:0] FIR_output;
  logic        [CH_W-1:0]      out_channel;
  logic                        output_valid;

  modport master (
    output FIR_input, in_channel, input_valid,
    output coef_wr_en, coef_addr, coef_data,
    input  ready_for_input, coef_wr_ignored,
    input  FIR_output, out_channel, output_valid
  );

  modport slave (
    input  FIR_input, in_channel, input_valid,
    input  coef_wr_en, coef_addr, coef_data,
    output ready_for_input, coef_wr_ignored,
    output FIR_output, out_channel, output_valid
  );
endinterface

// File: rtl/fir_filter_mc.sv
// Multi-channel FIR filter: one time-multiplexed MAC serves CHANNELS
// independent delay lines, with runtime-loadable coefficients and a
// MULT_STAGES-deep multiplier pipeline.
// Optional feature macro FIR_SAT_OUT_EN: when defined, the accumulator is
// shifted right by FRAC_BITS and saturated to the signed WIDTH range, at the
// cost of one extra register stage of latency.
module fir_filter_mc #(
  parameter int WIDTH       = 16,
  parameter int LENGTH      = 8,
  parameter int CHANNELS    = 4,
  parameter int MULT_STAGES = 4,
  parameter int OUT_WIDTH   = 2*WIDTH+$clog2(LENGTH),
  parameter int FRAC_BITS   = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  fir_filter_mc_if.slave  bus
);

  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ADDR_W  = $clog2(LENGTH);
  localparam int DRAIN_W = (MULT_STAGES > 1) ? $clog2(MULT_STAGES) : 1;
  localparam int PROD_W  = 2*WIDTH;
  localparam int EXT_W   = OUT_WIDTH-PROD_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CALC,
    DRAIN,
    OUTPUT
  } state_t;

  state_t state;

  logic signed [WIDTH-1:0]     x_mem [CHANNELS][LENGTH];
  logic signed [WIDTH-1:0]     coef [LENGTH];
  logic signed [PROD_W-1:0]    prod_pipe [MULT_STAGES];
  logic signed [OUT_WIDTH-1:0] acc;
  logic signed [WIDTH-1:0]     sample;
  logic        [CH_W-1:0]      cur_ch;
  logic        [ADDR_W-1:0]    tap;
  logic        [DRAIN_W-1:0]   drain_cnt;
  logic                        counter_co;

  logic signed [WIDTH-1:0]     tap_sample;
  logic signed [WIDTH-1:0]     tap_coef;
  logic signed [PROD_W-1:0]    mul_a;
  logic signed [PROD_W-1:0]    mul_b;
  logic signed [PROD_W-1:0]    mul_p;
  logic signed [PROD_W-1:0]    pipe_tail;
  logic signed [OUT_WIDTH-1:0] pipe_tail_ext;
  logic signed [OUT_WIDTH-1:0] acc_final;

  logic in_channel_ok;
  logic coef_addr_ok;

  // An out-of-range FRAC_BITS leaves this empty marker scope in the hierarchy.
  if (FRAC_BITS < 0 || FRAC_BITS >= OUT_WIDTH) begin : g_frac_bits_out_of_range
  end

  assign counter_co    = (tap == ADDR_W'(LENGTH-1));
  assign in_channel_ok = (int'(bus.in_channel) < CHANNELS);
  assign coef_addr_ok  = (int'(bus.coef_addr) < LENGTH);

  // Current tap product and the accumulator value including the product leaving the pipeline.
  always_comb begin
    tap_sample    = x_mem[cur_ch][tap];
    tap_coef      = coef[tap];
    mul_a         = {{WIDTH{tap_sample[WIDTH-1]}}, tap_sample};
    mul_b         = {{WIDTH{tap_coef[WIDTH-1]}}, tap_coef};
    mul_p         = mul_a * mul_b;
    pipe_tail     = prod_pipe[MULT_STAGES-1];
    pipe_tail_ext = {{EXT_W{pipe_tail[PROD_W-1]}}, pipe_tail};
    acc_final     = acc + pipe_tail_ext;
  end

`ifdef FIR_SAT_OUT_EN
  localparam logic signed [OUT_WIDTH-1:0] SAT_MAX =
    {{(OUT_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] SAT_MIN =
    {{(OUT_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [OUT_WIDTH-1:0] acc_shifted;
  logic signed [OUT_WIDTH-1:0] sat_result;
  logic signed [OUT_WIDTH-1:0] sat_val;
  logic                        sat_pending;

  // Fixed-point rescale of the finished sum, clamped to the sample range.
  always_comb begin
    acc_shifted = acc_final >>> FRAC_BITS;
    if (acc_shifted > SAT_MAX) begin
      sat_result = SAT_MAX;
    end else if (acc_shifted < SAT_MIN) begin
      sat_result = SAT_MIN;
    end else begin
      sat_result = acc_shifted;
    end
  end
`endif

  // Control FSM, delay lines, coefficient bank, multiplier pipeline and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      bus.ready_for_input <= 1'b1;
      bus.output_valid    <= 1'b0;
      bus.coef_wr_ignored <= 1'b0;
      bus.FIR_output      <= '0;
      bus.out_channel     <= '0;
      acc                 <= '0;
      sample              <= '0;
      cur_ch              <= '0;
      tap                 <= '0;
      drain_cnt           <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < LENGTH; k++) begin
          x_mem[c][k] <= '0;
        end
      end
      for (int k = 0; k < LENGTH; k++) begin
        coef[k] <= '0;
      end
      for (int i = 0; i < MULT_STAGES; i++) begin
        prod_pipe[i] <= '0;
      end
`ifdef FIR_SAT_OUT_EN
      sat_val     <= '0;
      sat_pending <= 1'b0;
`endif
    end else begin
      bus.output_valid    <= 1'b0;
      bus.coef_wr_ignored <= 1'b0;

      // Zeros are pushed whenever no tap is issued, so the tail is only ever
      // non-zero with a live product and can be summed unconditionally.
      prod_pipe[0] <= (state == CALC) ? mul_p : '0;
      for (int i = 1; i < MULT_STAGES; i++) begin
        prod_pipe[i] <= prod_pipe[i-1];
      end

      if (bus.coef_wr_en) begin
        if (state == IDLE) begin
          if (coef_addr_ok) begin
            coef[bus.coef_addr] <= bus.coef_data;
          end
        end else begin
          bus.coef_wr_ignored <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (bus.input_valid && in_channel_ok) begin
            sample              <= bus.FIR_input;
            cur_ch              <= bus.in_channel;
            bus.ready_for_input <= 1'b0;
            state               <= LOAD;
          end
        end

        LOAD: begin
          x_mem[cur_ch][0] <= sample;
          for (int k = 1; k < LENGTH; k++) begin
            x_mem[cur_ch][k] <= x_mem[cur_ch][k-1];
          end
          acc   <= '0;
          tap   <= '0;
          state <= CALC;
        end

        CALC: begin
          acc <= acc_final;
          tap <= tap + 1'b1;
          if (counter_co) begin
            drain_cnt <= '0;
            state     <= DRAIN;
          end
        end

        DRAIN: begin
          acc       <= acc_final;
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_W'(MULT_STAGES-1)) begin
            state <= OUTPUT;
`ifdef FIR_SAT_OUT_EN
            sat_val     <= sat_result;
            sat_pending <= 1'b1;
`else
            bus.FIR_output   <= acc_final;
            bus.out_channel  <= cur_ch;
            bus.output_valid <= 1'b1;
`endif
          end
        end

        OUTPUT: begin
`ifdef FIR_SAT_OUT_EN
          if (sat_pending) begin
            bus.FIR_output   <= sat_val;
            bus.out_channel  <= cur_ch;
            bus.output_valid <= 1'b1;
            sat_pending      <= 1'b0;
          end else begin
            bus.ready_for_input <= 1'b1;
            state               <= IDLE;
          end
`else
          bus.ready_for_input <= 1'b1;
          state               <= IDLE;
`endif
        end

        default: begin
          bus.ready_for_input <= 1'b1;
          state               <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Testbench for fir_filter_mc: directed scenarios plus randomized traffic,
// all compared against a per-channel history/coefficient model of the filter.
// Honors FIR_SAT_OUT_EN the same way the design does.
module tb_fir_filter_mc;

  localparam int WIDTH       = 16;
  localparam int LENGTH      = 8;
  localparam int CHANNELS    = 4;
  localparam int MULT_STAGES = 4;
  localparam int OUT_WIDTH   = 2*WIDTH+$clog2(LENGTH);
  localparam int FRAC_BITS   = 15;
  localparam int CH_W        = $clog2(CHANNELS);
  localparam int ADDR_W      = $clog2(LENGTH);
  localparam int TIMEOUT     = 200;
`ifdef FIR_SAT_OUT_EN
  localparam int LATENCY     = LENGTH+MULT_STAGES+3;
`else
  localparam int LATENCY     = LENGTH+MULT_STAGES+2;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int num_checks = 0;
  int num_errors = 0;

  longint coef_model [LENGTH];
  longint hist [CHANNELS][$];

  fir_filter_mc_if #(
    .WIDTH(WIDTH), .LENGTH(LENGTH), .CHANNELS(CHANNELS), .OUT_WIDTH(OUT_WIDTH)
  ) bus ();

  fir_filter_mc #(
    .WIDTH(WIDTH), .LENGTH(LENGTH), .CHANNELS(CHANNELS),
    .MULT_STAGES(MULT_STAGES), .OUT_WIDTH(OUT_WIDTH), .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    num_checks++;
    if (actual != expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic void clearModel();
    for (int c = 0; c < CHANNELS; c++) begin
      hist[c].delete();
      for (int k = 0; k < LENGTH; k++) hist[c].push_back(0);
    end
    for (int k = 0; k < LENGTH; k++) coef_model[k] = 0;
  endfunction

  function automatic longint expectedOutput(input int ch);
    longint sum = 0;
    for (int k = 0; k < LENGTH; k++) sum += hist[ch][k] * coef_model[k];
`ifdef FIR_SAT_OUT_EN
    sum = sum >>> FRAC_BITS;
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
`endif
    return sum;
  endfunction

  function automatic longint randomSample();
    logic signed [WIDTH-1:0] r;
    r = WIDTH'($urandom);
    return longint'(r);
  endfunction

  task automatic writeCoef(input int addr, input longint data);
    @(negedge clk);
    bus.coef_wr_en = 1'b1;
    bus.coef_addr  = ADDR_W'(addr);
    bus.coef_data  = WIDTH'(data);
    @(posedge clk);
    coef_model[addr] = data;
    @(negedge clk);
    bus.coef_wr_en = 1'b0;
    checkOutput("idle_write_not_ignored", longint'(bus.coef_wr_ignored), 0);
  endtask

  task automatic writeAllCoefs(input longint data);
    for (int k = 0; k < LENGTH; k++) writeCoef(k, data);
  endtask

  // One sample through the filter; optional coef write in the handshake cycle or while busy.
  task automatic applyStimulus(input int ch, input longint smp, input bit busy_write, input bit hs_write);
    int cyc;
    int ign_pulses;
    int hs_addr;
    longint hs_data;
    longint expected;
    hs_addr = $urandom_range(0, LENGTH-1);
    hs_data = randomSample();
    @(negedge clk);
    checkOutput("ready_before_handshake", longint'(bus.ready_for_input), 1);
    bus.FIR_input   = WIDTH'(smp);
    bus.in_channel  = CH_W'(ch);
    bus.input_valid = 1'b1;
    if (hs_write) begin
      bus.coef_wr_en = 1'b1;
      bus.coef_addr  = ADDR_W'(hs_addr);
      bus.coef_data  = WIDTH'(hs_data);
    end
    @(posedge clk);
    if (hs_write) coef_model[hs_addr] = hs_data;
    hist[ch].push_front(smp);
    void'(hist[ch].pop_back());
    expected = expectedOutput(ch);
    @(negedge clk);
    bus.input_valid = 1'b1;
    bus.FIR_input   = WIDTH'($urandom);
    bus.coef_wr_en  = 1'b0;
    cyc = 1;
    ign_pulses = 0;
    while (!bus.output_valid && cyc < TIMEOUT) begin
      if (busy_write && cyc == 4) begin
        bus.coef_wr_en = 1'b1;
        bus.coef_addr  = ADDR_W'($urandom_range(0, LENGTH-1));
        bus.coef_data  = WIDTH'($urandom);
      end else begin
        bus.coef_wr_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (bus.coef_wr_ignored) ign_pulses++;
    end
    bus.input_valid = 1'b0;
    bus.coef_wr_en  = 1'b0;
    checkOutput("latency", longint'(cyc), longint'(LATENCY));
    checkOutput("fir_output", longint'(bus.FIR_output), expected);
    checkOutput("out_channel", longint'(bus.out_channel), longint'(ch));
    checkOutput("ready_low_at_output", longint'(bus.ready_for_input), 0);
    if (busy_write) checkOutput("busy_write_ignored_pulses", longint'(ign_pulses), 1);
    else checkOutput("no_ignored_pulse", longint'(ign_pulses), 0);
    @(negedge clk);
    checkOutput("valid_one_cycle", longint'(bus.output_valid), 0);
    checkOutput("ready_after_output", longint'(bus.ready_for_input), 1);
    checkOutput("output_held", longint'(bus.FIR_output), expected);
  endtask

  // Start a ch0 computation, pull reset during DRAIN and confirm it is aborted.
  task automatic resetMidOperation();
    int cyc;
    int stray_valid;
    stray_valid = 0;
    @(negedge clk);
    bus.FIR_input   = WIDTH'(16'sd1000);
    bus.in_channel  = '0;
    bus.input_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.input_valid = 1'b0;
    cyc = 1;
    while (cyc < LENGTH+3) begin
      @(negedge clk);
      cyc++;
      if (bus.output_valid) stray_valid++;
    end
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_ready", longint'(bus.ready_for_input), 1);
    checkOutput("midreset_valid", longint'(bus.output_valid), 0);
    checkOutput("midreset_output", longint'(bus.FIR_output), 0);
    checkOutput("midreset_channel", longint'(bus.out_channel), 0);
    repeat (3) begin
      @(negedge clk);
      if (bus.output_valid) stray_valid++;
    end
    reset_n = 1'b1;
    repeat (LATENCY+2) begin
      @(negedge clk);
      if (bus.output_valid) stray_valid++;
    end
    checkOutput("aborted_no_valid", longint'(stray_valid), 0);
    clearModel();
  endtask

  initial begin
    bus.FIR_input   = '0;
    bus.in_channel  = '0;
    bus.input_valid = 1'b0;
    bus.coef_wr_en  = 1'b0;
    bus.coef_addr   = '0;
    bus.coef_data   = '0;
    clearModel();

    repeat (3) @(negedge clk);
    checkOutput("reset_ready", longint'(bus.ready_for_input), 1);
    checkOutput("reset_valid", longint'(bus.output_valid), 0);
    checkOutput("reset_ignored", longint'(bus.coef_wr_ignored), 0);
    checkOutput("reset_output", longint'(bus.FIR_output), 0);
    checkOutput("reset_channel", longint'(bus.out_channel), 0);
    reset_n = 1'b1;

    $display("[TB] impulse on channel 0");
    for (int k = 0; k < LENGTH; k++) writeCoef(k, k+1);
    applyStimulus(0, 1, 1'b0, 1'b0);
    for (int i = 1; i < LENGTH; i++) applyStimulus(0, 0, 1'b0, 1'b0);

    $display("[TB] channel isolation");
    writeAllCoefs(1);
    applyStimulus(1, 100, 1'b0, 1'b0);
    applyStimulus(2, 5, 1'b0, 1'b0);
    applyStimulus(1, 100, 1'b0, 1'b0);

    $display("[TB] extreme values on channel 3");
    writeAllCoefs(-32768);
    for (int i = 0; i < LENGTH; i++) applyStimulus(3, -32768, 1'b0, 1'b0);

    $display("[TB] positive full scale on channel 1");
    writeAllCoefs(32767);
    for (int i = 0; i < LENGTH; i++) applyStimulus(1, 32767, 1'b0, 1'b0);

    $display("[TB] coefficient write while busy");
    for (int k = 0; k < LENGTH; k++) writeCoef(k, randomSample());
    applyStimulus(2, 1234, 1'b1, 1'b0);
    applyStimulus(2, -77, 1'b0, 1'b0);
    applyStimulus(2, 31000, 1'b1, 1'b0);

    $display("[TB] reset during drain");
    resetMidOperation();
    for (int k = 0; k < LENGTH; k++) writeCoef(k, randomSample());
    applyStimulus(0, 1, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) writeCoef($urandom_range(0, LENGTH-1), randomSample());
      applyStimulus($urandom_range(0, CHANNELS-1), randomSample(), 1'b0, ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
